// File: rtl/rom_arbiter.sv
// rom_arbiter: round-robin arbiter/sequencer sharing one SPI flash ROM read
// path between port 0 (68040 bus interface) and port 1 (boot-copy/DMA).
// One read is outstanding at a time. A watchdog fails reads the flash never
// answers, and a later stale ack is drained before the next grant.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   mN_req_i/addr_i/sel_i        port N level request, word address, byte lanes
//   mN_ack_o/err_o               port N one-cycle completion, timeout flag
//   rdata_o                      shared read data, valid with mN_ack_o
//   rom_stb_o/addr_o/sel_o       one-cycle read strobe and latched request
//   rom_ack_i/odata_i            ROM reader completion and data
//   busy_o                       high whenever the sequencer is not idle
module rom_arbiter #(
  parameter int unsigned TIMEOUT  = 1000,
  parameter logic [31:0] ERR_DATA = 32'hFFFF_FFFF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_req_i,
  input  logic [21:0] m0_addr_i,
  input  logic [3:0]  m0_sel_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic        m1_req_i,
  input  logic [21:0] m1_addr_i,
  input  logic [3:0]  m1_sel_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] rdata_o,
  output logic        rom_stb_o,
  output logic [21:0] rom_addr_o,
  output logic [3:0]  rom_sel_o,
  input  logic        rom_ack_i,
  input  logic [31:0] rom_odata_i,
  output logic        busy_o
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned ADDR_W = 22;
  localparam int unsigned SEL_W  = 4;
  localparam int unsigned DATA_W = 32;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP,
    S_DRAIN
  } state_e;

  state_e              state_q, state_d;
  logic                gnt_q, gnt_d;
  logic                last_q, last_d;
  logic                drain_q, drain_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                rom_stb_q, rom_stb_d;
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic [SEL_W-1:0]    rom_sel_q, rom_sel_d;
  logic [1:0]          ack_q, ack_d;
  logic [1:0]          err_q, err_d;
  logic                busy_q, busy_d;

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_d     = last_q;
    drain_d    = drain_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    rom_stb_d  = 1'b0;
    rom_addr_d = rom_addr_q;
    rom_sel_d  = rom_sel_q;
    ack_d      = 2'b00;
    err_d      = 2'b00;

    case (state_q)
      S_IDLE: begin
        if (m0_req_i || m1_req_i) begin
          // On a tie, the port that did not win last time goes first.
          gnt_d      = (m0_req_i && m1_req_i) ? ~last_q : m1_req_i;
          rom_addr_d = gnt_d ? m1_addr_i : m0_addr_i;
          rom_sel_d  = gnt_d ? m1_sel_i : m0_sel_i;
          rom_stb_d  = 1'b1;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d = '0;
        if (rom_ack_i) begin
          rdata_d       = rom_odata_i;
          ack_d[gnt_q]  = 1'b1;
          state_d       = S_RESP;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (rom_ack_i) begin
          rdata_d      = rom_odata_i;
          ack_d[gnt_q] = 1'b1;
          state_d      = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          // Flash is presumed hung; its ack may still arrive later.
          rdata_d      = ERR_DATA;
          ack_d[gnt_q] = 1'b1;
          err_d[gnt_q] = 1'b1;
          drain_d      = 1'b1;
          state_d      = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP: begin
        last_d  = gnt_q;
        state_d = drain_q ? S_DRAIN : S_IDLE;
      end
      S_DRAIN: begin
        // Swallow the stale ack without touching rdata.
        if (rom_ack_i) begin
          drain_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      gnt_q      <= 1'b0;
      last_q     <= 1'b1;
      drain_q    <= 1'b0;
      cnt_q      <= '0;
      rdata_q    <= '0;
      rom_stb_q  <= 1'b0;
      rom_addr_q <= '0;
      rom_sel_q  <= '0;
      ack_q      <= 2'b00;
      err_q      <= 2'b00;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_q     <= last_d;
      drain_q    <= drain_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      rom_stb_q  <= rom_stb_d;
      rom_addr_q <= rom_addr_d;
      rom_sel_q  <= rom_sel_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
    end
  end

  assign m0_ack_o   = ack_q[0];
  assign m1_ack_o   = ack_q[1];
  assign m0_err_o   = err_q[0];
  assign m1_err_o   = err_q[1];
  assign rdata_o    = rdata_q;
  assign rom_stb_o  = rom_stb_q;
  assign rom_addr_o = rom_addr_q;
  assign rom_sel_o  = rom_sel_q;
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: instance a (default TIMEOUT) with a behavioral ROM,
// instance b (TIMEOUT=8) with a hand-driven ROM for the watchdog/drain path.
module tb_rom_arbiter;

  logic clk;
  logic rst;

  logic        a_m0_req, a_m1_req, a_m0_ack, a_m1_ack, a_m0_err, a_m1_err;
  logic [21:0] a_m0_addr, a_m1_addr, a_rom_addr;
  logic [3:0]  a_m0_sel, a_m1_sel, a_rom_sel;
  logic [31:0] a_rdata, a_rom_odata;
  logic        a_rom_stb, a_rom_ack, a_busy;

  logic        b_m0_req, b_m1_req, b_m0_ack, b_m1_ack, b_m0_err, b_m1_err;
  logic [21:0] b_m0_addr, b_m1_addr, b_rom_addr;
  logic [3:0]  b_m0_sel, b_m1_sel, b_rom_sel;
  logic [31:0] b_rdata, b_rom_odata;
  logic        b_rom_stb, b_rom_ack, b_busy;

  rom_arbiter u_dut_a (
    .clk_i(clk), .rst_i(rst),
    .m0_req_i(a_m0_req), .m0_addr_i(a_m0_addr), .m0_sel_i(a_m0_sel),
    .m0_ack_o(a_m0_ack), .m0_err_o(a_m0_err),
    .m1_req_i(a_m1_req), .m1_addr_i(a_m1_addr), .m1_sel_i(a_m1_sel),
    .m1_ack_o(a_m1_ack), .m1_err_o(a_m1_err),
    .rdata_o(a_rdata), .rom_stb_o(a_rom_stb), .rom_addr_o(a_rom_addr),
    .rom_sel_o(a_rom_sel), .rom_ack_i(a_rom_ack), .rom_odata_i(a_rom_odata),
    .busy_o(a_busy)
  );

  rom_arbiter #(.TIMEOUT(8)) u_dut_b (
    .clk_i(clk), .rst_i(rst),
    .m0_req_i(b_m0_req), .m0_addr_i(b_m0_addr), .m0_sel_i(b_m0_sel),
    .m0_ack_o(b_m0_ack), .m0_err_o(b_m0_err),
    .m1_req_i(b_m1_req), .m1_addr_i(b_m1_addr), .m1_sel_i(b_m1_sel),
    .m1_ack_o(b_m1_ack), .m1_err_o(b_m1_err),
    .rdata_o(b_rdata), .rom_stb_o(b_rom_stb), .rom_addr_o(b_rom_addr),
    .rom_sel_o(b_rom_sel), .rom_ack_i(b_rom_ack), .rom_odata_i(b_rom_odata),
    .busy_o(b_busy)
  );

  typedef struct {
    logic        port;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   a_stb_cnt = 0;
  int   b_stb_cnt = 0;
  int   proto_cnt = 0;
  logic [21:0] a_stb_addr = '0;
  logic [3:0]  a_stb_sel = '0;
  bit   chk_proto = 0;
  int   rom_dly = 4;
  bit   rom_fixed = 0;
  bit   rom_never = 0;

  function automatic logic [31:0] rom_word(input logic [21:0] addr);
    return {10'h2A5, addr};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench did not finish");
  end

  // Behavioral ROM reader for instance a: acks rom_dly cycles after a strobe.
  initial begin
    int          cnt;
    bit          pend;
    logic [21:0] raddr;
    cnt = 0;
    pend = 0;
    raddr = '0;
    a_rom_ack = 1'b0;
    a_rom_odata = '0;
    forever begin
      @(posedge clk);
      if (rst) begin
        pend = 0;
        a_rom_ack <= 1'b0;
      end else begin
        a_rom_ack <= 1'b0;
        if (a_rom_stb) begin
          pend = 1;
          cnt = rom_dly;
          raddr = a_rom_addr;
        end else if (pend && !rom_never) begin
          if (cnt <= 1) begin
            a_rom_ack   <= 1'b1;
            a_rom_odata <= rom_fixed ? 32'hDEADBEEF : rom_word(raddr);
            pend = 0;
          end else begin
            cnt--;
          end
        end
      end
    end
  end

  // Monitor: strobe counting, scoreboard pops on acks, protocol checker.
  initial begin
    exp_t e;
    logic a_rom_ack_prev;
    logic a_m0_ack_prev;
    a_rom_ack_prev = 1'b0;
    a_m0_ack_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (a_rom_stb) begin
        a_stb_cnt++;
        a_stb_addr = a_rom_addr;
        a_stb_sel = a_rom_sel;
      end
      if (b_rom_stb) b_stb_cnt++;
      if (a_m0_ack || a_m1_ack) begin
        chk("ack_onehot", 32'(a_m0_ack & a_m1_ack), 32'd0);
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL sb_unexpected_ack observed=ack expected=none");
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("ack_port", 32'(a_m1_ack), 32'(e.port));
          chk("ack_rdata", a_rdata, e.data);
          chk("ack_err", 32'(a_m1_ack ? a_m1_err : a_m0_err), 32'(e.err));
          chk("ack_after_rom_ack", 32'(a_rom_ack_prev), 32'd1);
        end
      end
      if (chk_proto && a_m0_req && a_m0_ack_prev) begin
        proto_cnt++;
        $display("note: port 0 req still high the cycle after its ack");
      end
      a_rom_ack_prev = a_rom_ack;
      a_m0_ack_prev = a_m0_ack;
    end
  end

  task automatic port_read(input bit p, input logic [21:0] addr);
    int n;
    n = 0;
    if (p) begin
      a_m1_addr = addr; a_m1_sel = 4'hF; a_m1_req = 1'b1;
    end else begin
      a_m0_addr = addr; a_m0_sel = 4'hF; a_m0_req = 1'b1;
    end
    do begin
      step();
      n++;
    end while (!(p ? a_m1_ack : a_m0_ack) && n < 300);
    chk(p ? "p1_ack_wait" : "p0_ack_wait", 32'(p ? a_m1_ack : a_m0_ack), 32'd1);
    if (p) a_m1_req = 1'b0;
    else   a_m0_req = 1'b0;
  endtask

  task automatic drain_sb();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      step();
      n++;
    end
    chk("sb_drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int n;
    int base;
    rst = 1'b1;
    a_m0_req = 0; a_m0_addr = '0; a_m0_sel = '0;
    a_m1_req = 0; a_m1_addr = '0; a_m1_sel = '0;
    b_m0_req = 0; b_m0_addr = '0; b_m0_sel = '0;
    b_m1_req = 0; b_m1_addr = '0; b_m1_sel = '0;
    b_rom_ack = 0; b_rom_odata = '0;
    repeat (3) step();
    rst = 1'b0;

    // Reset values.
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_stb", 32'(a_rom_stb), 32'd0);
    chk("rst_addr", 32'(a_rom_addr), 32'd0);
    chk("rst_rdata", a_rdata, 32'd0);
    chk("rst_acks", 32'({a_m0_ack, a_m1_ack, a_m0_err, a_m1_err}), 32'd0);

    // Simultaneous requests: grants alternate 0,1,0,1 starting with port 0.
    base = a_stb_cnt;
    rom_dly = 4;
    exp_q.push_back('{1'b0, rom_word(22'h000100), 1'b0});
    exp_q.push_back('{1'b1, rom_word(22'h000200), 1'b0});
    exp_q.push_back('{1'b0, rom_word(22'h000101), 1'b0});
    exp_q.push_back('{1'b1, rom_word(22'h000201), 1'b0});
    fork
      begin port_read(1'b0, 22'h000100); port_read(1'b0, 22'h000101); end
      begin port_read(1'b1, 22'h000200); port_read(1'b1, 22'h000201); end
    join
    drain_sb();
    chk("tie_stb_count", 32'(a_stb_cnt - base), 32'd4);

    // Single read on port 0 with a slow ROM.
    base = a_stb_cnt;
    rom_dly = 40;
    rom_fixed = 1;
    exp_q.push_back('{1'b0, 32'hDEADBEEF, 1'b0});
    port_read(1'b0, 22'h000010);
    rom_fixed = 0;
    chk("single_stb_count", 32'(a_stb_cnt - base), 32'd1);
    chk("single_rom_addr", 32'(a_stb_addr), 32'h10);
    chk("single_rom_sel", 32'(a_stb_sel), 32'hF);
    step();
    chk("single_idle_busy", 32'(a_busy), 32'd0);

    // Port 1 streaming, port 0 arrives mid-read and is served next.
    rom_dly = 10;
    exp_q.push_back('{1'b1, rom_word(22'h000300), 1'b0});
    exp_q.push_back('{1'b0, rom_word(22'h000400), 1'b0});
    exp_q.push_back('{1'b1, rom_word(22'h000301), 1'b0});
    fork
      begin port_read(1'b1, 22'h000300); port_read(1'b1, 22'h000301); end
      begin repeat (5) step(); port_read(1'b0, 22'h000400); end
    join
    drain_sb();

    // Reset mid-WAIT abandons the read without an ack.
    rom_never = 1;
    base = a_stb_cnt;
    a_m0_addr = 22'h000003; a_m0_sel = 4'h5; a_m0_req = 1'b1;
    n = 0;
    while (!a_rom_stb && n < 10) begin step(); n++; end
    chk("rstw_stb_seen", 32'(a_rom_stb), 32'd1);
    repeat (3) step();
    chk("rstw_busy", 32'(a_busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    a_m0_req = 1'b0;
    chk("rstw_stb", 32'(a_rom_stb), 32'd0);
    chk("rstw_addr", 32'(a_rom_addr), 32'd0);
    chk("rstw_sel", 32'(a_rom_sel), 32'd0);
    chk("rstw_rdata", a_rdata, 32'd0);
    chk("rstw_acks", 32'({a_m0_ack, a_m1_ack, a_m0_err, a_m1_err}), 32'd0);
    chk("rstw_busy_clr", 32'(a_busy), 32'd0);
    rom_never = 0;
    repeat (20) step();
    chk("rstw_no_reissue", 32'(a_stb_cnt - base), 32'd1);

    // Requester holds req one cycle past its ack: a second read is issued.
    chk_proto = 1;
    base = a_stb_cnt;
    exp_q.push_back('{1'b0, rom_word(22'h000050), 1'b0});
    exp_q.push_back('{1'b0, rom_word(22'h000050), 1'b0});
    a_m0_addr = 22'h000050; a_m0_sel = 4'hF; a_m0_req = 1'b1;
    n = 0;
    do begin step(); n++; end while (!a_m0_ack && n < 100);
    chk("proto_first_ack", 32'(a_m0_ack), 32'd1);
    step();
    step();
    a_m0_req = 1'b0;
    drain_sb();
    chk_proto = 0;
    chk("proto_flagged", 32'(proto_cnt), 32'd1);
    chk("proto_stb_count", 32'(a_stb_cnt - base), 32'd2);

    // Watchdog on instance b (TIMEOUT=8) and drain of the late ack.
    base = b_stb_cnt;
    b_m0_addr = 22'h000ABC; b_m0_sel = 4'h3; b_m0_req = 1'b1;
    n = 0;
    while (!b_rom_stb && n < 10) begin step(); n++; end
    chk("to_stb", 32'(b_rom_stb), 32'd1);
    chk("to_rom_addr", 32'(b_rom_addr), 32'hABC);
    n = 0;
    do begin step(); n++; end while (!b_m0_ack && n < 20);
    chk("to_ack", 32'(b_m0_ack), 32'd1);
    chk("to_latency", 32'(n), 32'd9);
    chk("to_err", 32'(b_m0_err), 32'd1);
    chk("to_rdata", b_rdata, 32'hFFFFFFFF);
    chk("to_m1_ack", 32'(b_m1_ack), 32'd0);
    b_m0_req = 1'b0;
    b_m1_addr = 22'h000155; b_m1_sel = 4'hF; b_m1_req = 1'b1;
    repeat (12) step();
    chk("drain_no_grant", 32'(b_stb_cnt - base), 32'd1);
    chk("drain_busy", 32'(b_busy), 32'd1);
    b_rom_odata = 32'h12345678;
    b_rom_ack = 1'b1;
    step();
    b_rom_ack = 1'b0;
    n = 0;
    while (!b_rom_stb && n < 10) begin step(); n++; end
    chk("post_drain_stb", 32'(b_rom_stb), 32'd1);
    chk("drain_discard", b_rdata, 32'hFFFFFFFF);
    chk("post_drain_addr", 32'(b_rom_addr), 32'h155);
    b_rom_odata = 32'hCAFEF00D;
    b_rom_ack = 1'b1;
    step();
    b_rom_ack = 1'b0;
    n = 0;
    while (!b_m1_ack && n < 5) begin step(); n++; end
    chk("p1_after_drain_ack", 32'(b_m1_ack), 32'd1);
    chk("p1_after_drain_rdata", b_rdata, 32'hCAFEF00D);
    chk("p1_after_drain_err", 32'(b_m1_err), 32'd0);
    chk("p1_after_drain_m0", 32'(b_m0_ack), 32'd0);
    b_m1_req = 1'b0;
    repeat (3) step();

    chk("sb_leftover", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rom_arbiter.md
# rom_arbiter

Two-port arbiter and sequencer placed in front of the SPI flash ROM reader. It shares the single ROM read path between the 68040 bus interface (port 0) and the boot-copy/DMA engine (port 1). Grants are round-robin and only one read is outstanding at a time. A watchdog returns an error to the requester if the flash never answers.

## Interface
Parameters:
- TIMEOUT, 1000: maximum cycles spent in WAIT before a read is failed; legal range 2..65535.
- ERR_DATA, 32'hFFFF_FFFF: value presented on mN_data for a timed-out read.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  synchronous, active-high reset.
- m0_req  in  1  port 0 request; level, held until m0_ack.
- m0_addr  in  22  port 0 word address; stable while m0_req.
- m0_sel  in  4  port 0 byte lanes; stable while m0_req.
- m0_ack  out  1  one-cycle completion pulse for port 0.
- m0_err  out  1  with m0_ack: read timed out.
- m1_req, m1_addr, m1_sel, m1_ack, m1_err: same as port 0, for port 1.
- rdata  out  32  read data shared by both ports; valid only in the cycle mN_ack is high.
- rom_stb  out  1  one-cycle read strobe to the ROM reader.
- rom_addr  out  22  latched address to the ROM reader.
- rom_sel  out  4  latched byte lanes to the ROM reader.
- rom_ack  in  1  one-cycle completion from the ROM reader.
- rom_odata  in  32  ROM read data, valid with rom_ack.
- busy  out  1  high in every state except IDLE.

## Operation
- State machine: IDLE, ISSUE, WAIT, RESP, DRAIN.
- IDLE:
  - If one port requests, grant it.
  - If both request, grant the port not granted last. The last-grant pointer resets to 1, so port 0 wins the first tie.
  - On grant: latch the address and sel into rom_addr/rom_sel, record the granted port, go to ISSUE.
- ISSUE: rom_stb=1 for exactly this cycle. Clear the watchdog counter, go to WAIT.
- WAIT:
  - rom_ack=1: latch rom_odata into rdata, set err=0, go to RESP.
  - rom_ack=0: counter increments. When the counter reaches TIMEOUT-1 without an ack, load ERR_DATA into rdata, set err=1, go to RESP with the drain flag set.
- rom_ack arriving in ISSUE is accepted exactly as in WAIT.
- RESP:
  - Granted port's mN_ack=1 and mN_err=err for one cycle; the other port's ack stays 0.
  - Update the last-grant pointer.
  - Next state is DRAIN if the drain flag is set, otherwise IDLE.
- DRAIN: no grants. Wait for the stale rom_ack, discard its data (rdata unchanged), clear the drain flag, go to IDLE. There is no timeout in DRAIN.
- Requester rule: drop mN_req on the same edge that samples mN_ack=1. A req still high in the following IDLE cycle is treated as a new read.
- Requests arriving while busy are held off, with no loss; a requester's addr/sel changes outside IDLE have no effect.
- rom_ack in IDLE or RESP is ignored.

## Timing
- Reset values: rom_stb=0, rom_addr=0, rom_sel=0, m0_ack=m1_ack=0, m0_err=m1_err=0, rdata=0, busy=0. State is IDLE, drain flag 0, last-grant pointer 1.
- Reset has priority in every state. Reset mid-read abandons the transfer with no ack. The ROM reader shares the system reset, so no drain is needed after reset.
- Cycle timeline (req first sampled at edge 0, IDLE):
  - Cycle 1: ISSUE, rom_stb=1.
  - Cycle 2 onward: WAIT.
  - rom_ack sampled at cycle k puts mN_ack at cycle k+1.
  - Minimum latency, with rom_ack in ISSUE: req to ack = 3 cycles.
- Back-to-back reads: IDLE lasts at least 1 cycle between RESP and the next ISSUE. Minimum spacing between rom_stb pulses is 4 cycles.
- Timeout: with no ack, WAIT lasts exactly TIMEOUT cycles, then RESP with err=1.
- Watchdog counter: 16 bits wide; cannot wrap because it stops at TIMEOUT-1.
- busy is registered and equals (state != IDLE).

## Test plan
- Single read, port 0: m0_req with addr 22'h000010, sel 4'hF; ROM model acks 40 cycles after rom_stb with 32'hDEADBEEF.
  - Exactly one rom_stb pulse; rom_addr=22'h000010.
  - m0_ack one cycle after rom_ack; rdata=32'hDEADBEEF, m0_err=0; m1_ack stays 0.
- Simultaneous requests held for 4 reads (2 per port): grants go 0,1,0,1. Each port's ack carries that port's address-derived data.
- Port 1 continuously requesting, port 0 raising req mid-read: port 0 is granted next after port 1's current read; neither port waits more than one other read.
- Timeout, TIMEOUT=8, ROM model never acks:
  - m0_ack with m0_err=1 and rdata=32'hFFFFFFFF exactly 8 WAIT cycles after ISSUE.
  - A port 1 request is not issued until a late rom_ack arrives. That ack's data is discarded; the port 1 read then proceeds.
- Reset mid-WAIT: rst=1 for 1 cycle during a read. All outputs return to reset values the next cycle, and no mN_ack is produced for the abandoned read.
- Requester holds req one cycle past ack: a second rom_stb is issued. A bench checker flags the protocol violation and the count of rom_stb pulses equals 2.
